step_counter: RTL and testbench

STEP_COUNTER -- requirements
Module: step_counter

---
 rtl/step_counter.sv | 80 ++++++++
 tb/tb_step_counter.sv | 137 +++++++++++++
 2 files changed

// File: rtl/step_counter.sv
// Up/down counter with inclusive MAX_VAL limit, wrap or saturate at the limits,
// parallel load, sticky limit-event flag, and a half-adder/half-subtractor step chain.

module step_cell (
  input  logic a,
  input  logic ci,
  input  logic up,
  output logic s,
  output logic co
);
  // Carry (up) or borrow (down) propagates only while the lower bits are all 1s / all 0s.
  assign s  = a ^ ci;
  assign co = (up ? a : ~a) & ci;
endmodule

module step_counter #(
  parameter int             WIDTH   = 4,
  parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             up,
  input  logic             sat,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             zero,
  output logic             ovf
);

  logic [WIDTH-1:0] carry;
  logic [WIDTH-1:0] step_q;
  logic [WIDTH-1:0] load_clamped;
  logic             at_max;
  logic             at_min;

  assign carry[0] = 1'b1;

  // The MSB has no use for a carry/borrow out, so it gets only the sum half.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    if (i < WIDTH-1) begin : g_chain
      step_cell u_cell (
        .a  (q[i]),
        .ci (carry[i]),
        .up (up),
        .s  (step_q[i]),
        .co (carry[i+1])
      );
    end else begin : g_msb
      assign step_q[i] = q[i] ^ carry[i];
    end
  end

  assign at_max       = (q == MAX_VAL);
  assign at_min       = (q == '0);
  assign load_clamped = (load_val > MAX_VAL) ? MAX_VAL : load_val;

  assign zero = at_min;
  assign tc   = en & ((up & at_max) | (~up & at_min));

  always_ff @(posedge clk) begin
    if (rst) begin
      q   <= '0;
      ovf <= 1'b0;
    end else if (load) begin
      q   <= load_clamped;
      ovf <= 1'b0;
    end else if (en) begin
      if (tc) begin
        ovf <= 1'b1;
        if (!sat) q <= up ? '0 : MAX_VAL;
      end else begin
        q <= step_q;
      end
    end
  end

endmodule

// File: tb/tb_step_counter.sv
// Directed-vector bench for step_counter: the driver queues hand-computed
// expectations, an independent monitor pops and compares them every cycle.

module tb_step_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b0, en = 1'b0, load = 1'b0, up = 1'b0, sat = 1'b0;
  logic [3:0] load_val = '0;

  logic [3:0] q9, q15;
  logic       tc9, tc15, zero9, zero15, ovf9, ovf15;

  always #5 clk = ~clk;

  step_counter #(.WIDTH(4), .MAX_VAL(4'd9)) dut9 (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
    .up(up), .sat(sat), .q(q9), .tc(tc9), .zero(zero9), .ovf(ovf9)
  );

  step_counter dut15 (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
    .up(up), .sat(sat), .q(q15), .tc(tc15), .zero(zero15), .ovf(ovf15)
  );

  typedef struct {
    string      name;
    bit         d;      // 0: MAX_VAL=9 instance, 1: default instance
    bit         ctc;    // check tc while the vector is applied
    logic       tc;
    logic [3:0] q;
    logic       ovf;
  } exp_t;

  exp_t sbq[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Driver: apply inputs on the falling edge and queue the expectation.
  task automatic step(input string nm, input logic r, l, input logic [3:0] lv,
                      input logic e, u, s, input bit d, input bit ctc,
                      input logic etc, input logic [3:0] eq, input logic eovf);
    exp_t it;
    @(negedge clk);
    rst = r; load = l; load_val = lv; en = e; up = u; sat = s;
    it.name = nm; it.d = d; it.ctc = ctc; it.tc = etc; it.q = eq; it.ovf = eovf;
    sbq.push_back(it);
  endtask

  // Monitor: tc mid-low-phase (pre-edge), then q/ovf/zero just after the edge.
  initial begin
    exp_t it;
    forever begin
      @(negedge clk);
      #2;
      if (sbq.size() > 0) begin
        it = sbq[0];
        if (it.ctc) chk({it.name, ".tc"}, {3'b0, it.d ? tc15 : tc9}, {3'b0, it.tc});
        @(posedge clk);
        #1;
        void'(sbq.pop_front());
        chk({it.name, ".q"},    it.d ? q15 : q9, it.q);
        chk({it.name, ".ovf"},  {3'b0, it.d ? ovf15 : ovf9}, {3'b0, it.ovf});
        chk({it.name, ".zero"}, {3'b0, it.d ? zero15 : zero9}, {3'b0, it.q == 4'd0});
      end
    end
  end

  initial begin
    int pre;
    // Reset state
    step("reset", 1, 0, 0, 0, 1, 0, 0, 0, 0, 4'd0, 0);
    // Count up with wrap, MAX_VAL=9: 1..9, 0, 1, 2; ovf from the 9->0 edge
    for (int i = 0; i < 12; i++) begin
      pre = (i < 10) ? i : i - 10;
      step("up_wrap", 0, 0, 0, 1, 1, 0, 0, 1, pre == 9, (pre == 9) ? 4'd0 : 4'(pre + 1), i >= 9);
    end
    // Load 2, then count down saturating: 1, 0, 0, 0
    step("load2", 0, 1, 4'd2, 0, 0, 1, 0, 1, 0, 4'd2, 0);
    step("dn_sat0", 0, 0, 0, 1, 0, 1, 0, 1, 0, 4'd1, 0);
    step("dn_sat1", 0, 0, 0, 1, 0, 1, 0, 1, 0, 4'd0, 0);
    step("dn_sat2", 0, 0, 0, 1, 0, 1, 0, 1, 1, 4'd0, 1);
    step("dn_sat3", 0, 0, 0, 1, 0, 1, 0, 1, 1, 4'd0, 1);
    // Load above MAX_VAL clamps to 9, beats en, clears ovf
    step("load15_en", 0, 1, 4'd15, 1, 1, 0, 0, 1, 0, 4'd9, 0);
    // up/sat toggled while en=0 have no effect
    step("hold_tgl0", 0, 0, 0, 0, 0, 1, 0, 1, 0, 4'd9, 0);
    step("hold_tgl1", 0, 0, 0, 0, 1, 0, 0, 1, 0, 4'd9, 0);
    // Saturate at top
    step("up_sat9", 0, 0, 0, 1, 1, 1, 0, 1, 1, 4'd9, 1);
    // Load 0, wrap down to 9, then count down to 5 with ovf sticky
    step("load0", 0, 1, 4'd0, 0, 1, 0, 0, 1, 0, 4'd0, 0);
    step("dn_wrap", 0, 0, 0, 1, 0, 0, 0, 1, 1, 4'd9, 1);
    step("dn8", 0, 0, 0, 1, 0, 0, 0, 1, 0, 4'd8, 1);
    step("dn7", 0, 0, 0, 1, 0, 0, 0, 1, 0, 4'd7, 1);
    step("dn6", 0, 0, 0, 1, 0, 0, 0, 1, 0, 4'd6, 1);
    step("dn5", 0, 0, 0, 1, 0, 0, 0, 1, 0, 4'd5, 1);
    // rst + load + en together at q=5
    step("rst_ld_en", 1, 1, 4'd7, 1, 1, 0, 0, 1, 0, 4'd0, 0);
    // After reset tc = en & ~up
    step("post_rst_tc", 0, 0, 0, 1, 0, 1, 0, 1, 1, 4'd0, 1);
    // Reset during a limit event
    step("load9", 0, 1, 4'd9, 0, 1, 0, 0, 1, 0, 4'd9, 0);
    step("rst_at_lim", 1, 0, 0, 1, 1, 0, 0, 1, 1, 4'd0, 0);
    // Toggle direction from q=3: 4, 3, 4, 3
    step("load3", 0, 1, 4'd3, 0, 1, 0, 0, 1, 0, 4'd3, 0);
    step("tog_up0", 0, 0, 0, 1, 1, 0, 0, 1, 0, 4'd4, 0);
    step("tog_dn0", 0, 0, 0, 1, 0, 0, 0, 1, 0, 4'd3, 0);
    step("tog_up1", 0, 0, 0, 1, 1, 0, 0, 1, 0, 4'd4, 0);
    step("tog_dn1", 0, 0, 0, 1, 0, 0, 0, 1, 0, 4'd3, 0);
    // Default parameters: 16 up-counts wrap 15->0, then hold
    step("rst15", 1, 0, 0, 0, 1, 0, 1, 0, 0, 4'd0, 0);
    for (int i = 0; i < 16; i++)
      step("up15", 0, 0, 0, 1, 1, 0, 1, 1, i == 15, 4'((i + 1) % 16), i == 15);
    for (int i = 0; i < 3; i++)
      step("hold15", 0, 0, 0, 0, 1, 0, 1, 1, 0, 4'd0, 1);

    @(negedge clk);
    en = 0; load = 0; rst = 0;
    for (int i = 0; i < 20 && sbq.size() > 0; i++) @(posedge clk);
    if (sbq.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
